// File: rtl/mem_pkg.sv
// Shared types and helpers for the FIFO read-side stream controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // Ceiling log2, evaluated at elaboration time to size counters.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry FIFO-ordered output buffer; the head entry drives the stream.
module stream_skid2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop_s;

  assign valid = (occ_q != 2'd0);
  assign dout  = head_q;
  assign occ   = occ_q;
  assign pop_s = valid & ready;

  // Next-state of the two entries: pop shifts tail to head, push fills the first free slot.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop_s})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = din;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          tail_d = din;
          occ_d  = 2'd2;
        end else begin
          occ_d = occ_q;
        end
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Buffer registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Read-side FIFO controller: issues READ, captures Q a cycle later and
// streams words out with burst framing and a running beat count.
module mem_stream_reader
  import mem_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             EMPTY,
  output logic             READ,
  input  logic [WIDTH-1:0] Q,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_LAST,
  output logic [CNT_W-1:0] BEATS,
  output logic             BUSY
);

  localparam int IDX_W = clog2(BURST_LEN) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  rd_state_t        state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] beats_q, beats_d;

  logic             busy_s;
  logic             skid_valid_s;
  logic [1:0]       occ_s;
  logic             pop_s;
  logic             credit_s;
  logic             read_s;

  assign busy_s = (state_q != IDLE);

  // The buffer never holds data in IDLE; gating keeps the stream quiet regardless.
  stream_skid2 #(.WIDTH(WIDTH)) u_skid (
    .clk   (CLK),
    .rstn  (RSTN),
    .push  (inflight_q),
    .din   (Q),
    .ready (OUT_READY & busy_s),
    .valid (skid_valid_s),
    .dout  (OUT_DATA),
    .occ   (occ_s)
  );

  // Read credit: a new word may be requested if it will find a free slot when it lands.
  always_comb begin
    pop_s    = skid_valid_s & busy_s & OUT_READY;
    credit_s = (({1'b0, occ_s} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}));
    read_s   = (state_q == RUN) & EN & ~EMPTY & credit_s;
  end

  // FSM next state; READ stops the same cycle EN falls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (EN) state_d = RUN;
        else    state_d = IDLE;
      end
      RUN: begin
        if (!EN) state_d = DRAIN;
        else     state_d = RUN;
      end
      DRAIN: begin
        if (EN)                                    state_d = RUN;
        else if ((occ_s == 2'd0) && !inflight_q)   state_d = IDLE;
        else                                       state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst index and beat counter advance on every accepted beat.
  always_comb begin
    inflight_d = read_s;
    idx_d      = idx_q;
    beats_d    = beats_q;
    if (pop_s) begin
      beats_d = beats_q + CNT_W'(1);
      if (idx_q == LAST_IDX) idx_d = '0;
      else                   idx_d = idx_q + IDX_W'(1);
    end else begin
      beats_d = beats_q;
      idx_d   = idx_q;
    end
  end

  // Control registers; reset discards any word still in flight.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      idx_q      <= '0;
      beats_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      idx_q      <= idx_d;
      beats_q    <= beats_d;
    end
  end

  assign READ      = read_s;
  assign OUT_VALID = skid_valid_s & busy_s;
  assign OUT_LAST  = OUT_VALID & (idx_q == LAST_IDX);
  assign BEATS     = beats_q;
  assign BUSY      = busy_s;

endmodule
